transmisor_param: RTL and testbench

Parametrised successor of the 4-lane transmitter. Accepts a symbol stream (data or K-control, tagged) through a valid/ready handshake into an input FIFO and stripes it across LANES lanes. Periodically inserts a SKP ordered set (COM word, then SKP word) at word boundaries for clock compensation. Sits between the data-link symbol source and the per-lane serialiser/encoder.

---
 rtl/transmisor_param.sv | 195 +++++++++++++++++++
 tb/tb_transmisor_param.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transmisor_param.sv
// Symbol striper: input FIFO -> LANES-wide words, with periodic COM/SKP ordered sets.
// Optional lane reversal is compiled in with `define TX_LANE_REVERSAL_EN.
module transmisor_param #(
    parameter int unsigned       LANES        = 4,
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       FIFO_DEPTH   = 8,
    parameter int unsigned       SKP_INTERVAL = 64,
    parameter logic [DATA_W-1:0] COM_SYM      = DATA_W'(8'hBC),
    parameter logic [DATA_W-1:0] SKP_SYM      = DATA_W'(8'h1C)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enb,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_k,
    input  logic                         in_valid,
`ifdef TX_LANE_REVERSAL_EN
    input  logic                         lane_rev,
`endif
    output logic                         in_ready,
    output logic [LANES*DATA_W-1:0]      tx_lanes,
    output logic [LANES-1:0]             tx_lane_k,
    output logic                         tx_valid,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CNT_W = $clog2(SKP_INTERVAL);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SKP_INTERVAL - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StData, StSkpCom, StSkpSkp} state_e;

    state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DATA_W:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    logic [LANES*DATA_W-1:0] build_q, build_d;
    logic [LANES-1:0]        build_k_q, build_k_d;
    logic [LANES*DATA_W-1:0] lanes_q, lanes_d;
    logic [LANES-1:0]        lane_k_q, lane_k_d;
    logic                    valid_q, valid_d;

    logic            full, empty, push, pop, skp_due, rev_cur;
    logic [DATA_W:0] rd_sym;
    logic [IDX_W-1:0] dest;

    assign full     = (level_q == FULL_LVL);
    assign empty    = (level_q == '0);
    assign in_ready = !rst && enb && !full;
    assign push     = in_valid && in_ready;
    // An ordered set is only started on a word boundary.
    assign skp_due  = (state_q == StData) && (cnt_q == CNT_MAX) && (idx_q == '0);
    assign pop      = enb && !rst && (state_q == StData) && !skp_due && !empty;
    assign rd_sym   = mem_q[rd_ptr_q];

`ifdef TX_LANE_REVERSAL_EN
    logic rev_q;

    // Direction is latched on the first symbol and held for the rest of the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rev_q <= 1'b0;
        end else if (pop && (idx_q == '0)) begin
            rev_q <= lane_rev;
        end
    end

    assign rev_cur = (idx_q == '0) ? lane_rev : rev_q;
`else
    assign rev_cur = 1'b0;
`endif

    assign dest = rev_cur ? (LAST_IDX - idx_q) : idx_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_k, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        build_d   = build_q;
        build_k_d = build_k_q;
        lanes_d   = lanes_q;
        lane_k_d  = lane_k_q;
        valid_d   = 1'b0;

        if (enb) begin
            unique case (state_q)
                StData: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (skp_due) begin
                        state_d = StSkpCom;
                    end else if (pop) begin
                        for (int unsigned i = 0; i < LANES; i++) begin
                            if (dest == IDX_W'(i)) begin
                                build_d[i*DATA_W +: DATA_W] = rd_sym[DATA_W-1:0];
                                build_k_d[i]                = rd_sym[DATA_W];
                            end
                        end
                        if (idx_q == LAST_IDX) begin
                            idx_d    = '0;
                            lanes_d  = build_d;
                            lane_k_d = build_k_d;
                            valid_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                StSkpCom, StSkpSkp: begin
                    // idx_q doubles as the per-symbol-time counter of the ordered set.
                    if (idx_q == LAST_IDX) begin
                        idx_d    = '0;
                        lane_k_d = '1;
                        valid_d  = 1'b1;
                        if (state_q == StSkpCom) begin
                            lanes_d = {LANES{COM_SYM}};
                            state_d = StSkpSkp;
                        end else begin
                            lanes_d = {LANES{SKP_SYM}};
                            state_d = StData;
                            cnt_d   = '0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                default: state_d = StData;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StData;
            idx_q     <= '0;
            cnt_q     <= '0;
            build_q   <= '0;
            build_k_q <= '0;
            lanes_q   <= '0;
            lane_k_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            build_q   <= build_d;
            build_k_q <= build_k_d;
            lanes_q   <= lanes_d;
            lane_k_q  <= lane_k_d;
            valid_q   <= valid_d;
        end
    end

    assign tx_lanes   = lanes_q;
    assign tx_lane_k  = lane_k_q;
    assign tx_valid   = valid_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_transmisor_param.sv
// Self-checking bench for transmisor_param: directed scenarios plus randomized traffic
// scored against a symbol-queue model.
module tb_transmisor_param;

    localparam int unsigned LANES        = 4;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned FIFO_DEPTH   = 8;
    localparam int unsigned SKP_INTERVAL = 16;
    localparam logic [7:0]  COM          = 8'hBC;
    localparam logic [7:0]  SKP          = 8'h1C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enb = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_k = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] tx_lanes;
    logic [3:0]  tx_lane_k;
    logic        tx_valid;
    logic [3:0]  fifo_level;
`ifdef TX_LANE_REVERSAL_EN
    logic        lane_rev = 1'b0;
`endif

    transmisor_param #(
        .LANES(LANES), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SKP_INTERVAL(SKP_INTERVAL),
        .COM_SYM(COM), .SKP_SYM(SKP)
    ) dut (
        .clk(clk), .rst(rst), .enb(enb), .in_data(in_data), .in_k(in_k),
        .in_valid(in_valid),
`ifdef TX_LANE_REVERSAL_EN
        .lane_rev(lane_rev),
`endif
        .in_ready(in_ready), .tx_lanes(tx_lanes), .tx_lane_k(tx_lane_k),
        .tx_valid(tx_valid), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lanes;
        logic [3:0]  k;
        int          cyc;
    } word_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    word_t       obs[$];
    logic [8:0]  model[$];
    word_t       data_w[$];
    int          com_idx[$];
    bit          pairs_ok;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_valid === 1'b1) obs.push_back('{tx_lanes, tx_lane_k, cyc});
    end

    task automatic drive_cycle(input bit v, input logic [7:0] d, input bit k, input bit e,
                               output bit acc);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        in_k     = k;
        enb      = e;
        @(negedge clk);
        acc = v && (in_ready === 1'b1);
        if (acc) model.push_back({k, d});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        enb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs.delete();
        model.delete();
    endtask

    // Splits the observed stream into data words and COM/SKP ordered sets.
    function automatic void classify();
        data_w.delete();
        com_idx.delete();
        pairs_ok = 1'b1;
        for (int i = 0; i < obs.size(); i++) begin
            if (obs[i].lanes === {4{COM}} && obs[i].k === 4'hF) begin
                com_idx.push_back(i);
                if (i + 1 >= obs.size() || obs[i+1].lanes !== {4{SKP}} || obs[i+1].k !== 4'hF)
                    pairs_ok = 1'b0;
                else
                    i++;
            end else begin
                data_w.push_back(obs[i]);
            end
        end
    endfunction

    function automatic logic [31:0] exp_lanes(int n);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = model[n*4+i][7:0];
        return r;
    endfunction

    function automatic logic [3:0] exp_k(int n);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = model[n*4+i][8];
        return r;
    endfunction

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; enb = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_k = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (tx_lanes !== 32'h0) begin errors++; $display("FAIL reset_lanes: got %h expected 0", tx_lanes); end
        checks++; if (tx_lane_k !== 4'h0) begin errors++; $display("FAIL reset_k: got %b expected 0000", tx_lane_k); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", tx_valid); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", in_ready); end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_stream();
        bit acc;
        int e0 = 0;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b1, 8'(i), 1'b0, 1'b1, acc);
            if (i == 1) e0 = cyc + 1;
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL stream_level: got %0d expected 1", fifo_level); end
        repeat (6) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        classify();
        checks++;
        if (data_w.size() != 2) begin
            errors++; $display("FAIL stream_count: got %0d expected 2", data_w.size());
        end else begin
            checks++; if (data_w[0].lanes !== 32'h04030201) begin errors++; $display("FAIL stream_w0: got %h expected 04030201", data_w[0].lanes); end
            checks++; if (data_w[0].cyc != e0 + 4) begin errors++; $display("FAIL stream_lat0: got %0d expected %0d", data_w[0].cyc, e0 + 4); end
            checks++; if (data_w[1].lanes !== 32'h08070605) begin errors++; $display("FAIL stream_w1: got %h expected 08070605", data_w[1].lanes); end
            checks++; if (data_w[1].cyc != e0 + 8) begin errors++; $display("FAIL stream_lat1: got %0d expected %0d", data_w[1].cyc, e0 + 8); end
            checks++; if ((data_w[0].k | data_w[1].k) !== 4'h0) begin errors++; $display("FAIL stream_k: got %b/%b expected 0000", data_w[0].k, data_w[1].k); end
        end
    endtask

    task automatic test_k_stall();
        bit acc;
        int p33 = 0;
        do_reset();
        drive_cycle(1'b1, COM, 1'b1, 1'b1, acc);
        drive_cycle(1'b1, 8'h11, 1'b0, 1'b1, acc);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
            if (i == 2) begin
                checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL stall_level: got %0d expected 0", fifo_level); end
                checks++; if (obs.size() != 0) begin errors++; $display("FAIL stall_early_valid: got %0d words expected 0", obs.size()); end
            end
        end
        drive_cycle(1'b1, 8'h22, 1'b0, 1'b1, acc);
        drive_cycle(1'b1, 8'h33, 1'b0, 1'b1, acc);
        p33 = cyc + 1;
        repeat (4) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        classify();
        checks++;
        if (data_w.size() != 1) begin
            errors++; $display("FAIL stall_count: got %0d expected 1", data_w.size());
        end else begin
            checks++; if (data_w[0].lanes !== 32'h332211BC) begin errors++; $display("FAIL stall_word: got %h expected 332211bc", data_w[0].lanes); end
            checks++; if (data_w[0].k !== 4'b0001) begin errors++; $display("FAIL stall_k: got %b expected 0001", data_w[0].k); end
            checks++; if (data_w[0].cyc != p33 + 1) begin errors++; $display("FAIL stall_time: got %0d expected %0d", data_w[0].cyc, p33 + 1); end
        end
    endtask

    task automatic test_skp_full();
        bit acc;
        int n = 0;
        int max_lvl = 0;
        int guard = 0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            drive_cycle(1'b1, 8'(n), 1'b0, 1'b1, acc);
            if (acc) n++;
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (fifo_level == 4'd8) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", in_ready); end
            end
        end
        while (model.size() % 4 != 0 && guard < 50) begin
            drive_cycle(1'b1, 8'(n), 1'b0, 1'b1, acc);
            if (acc) n++;
            guard++;
        end
        repeat (40) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        classify();
        checks++; if (max_lvl != 8) begin errors++; $display("FAIL full_level_max: got %0d expected 8", max_lvl); end
        checks++; if (!pairs_ok) begin errors++; $display("FAIL skp_pairs: got 0 expected 1"); end
        checks++;
        if (com_idx.size() == 0) begin
            errors++; $display("FAIL skp_present: got 0 sets expected >=1");
        end else begin
            checks++; if (com_idx[0] != 4) begin errors++; $display("FAIL skp_position: got %0d words before expected 4", com_idx[0]); end
            if (com_idx[0] + 1 < obs.size()) begin
                checks++;
                if (obs[com_idx[0]+1].cyc - obs[com_idx[0]].cyc != 4) begin
                    errors++; $display("FAIL skp_gap: got %0d expected 4", obs[com_idx[0]+1].cyc - obs[com_idx[0]].cyc);
                end
            end
        end
        checks++; if (data_w.size() != model.size() / 4) begin errors++; $display("FAIL full_words: got %0d expected %0d", data_w.size(), model.size() / 4); end
        for (int w = 0; w < data_w.size() && w < model.size() / 4; w++) begin
            checks++;
            if (data_w[w].lanes !== exp_lanes(w) || data_w[w].k !== exp_k(w)) begin
                errors++; $display("FAIL full_data[%0d]: got %h/%b expected %h/%b", w, data_w[w].lanes, data_w[w].k, exp_lanes(w), exp_k(w));
            end
        end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL full_drain: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_enb_freeze();
        bit acc;
        do_reset();
        for (int i = 1; i <= 4; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 8'hEE, 1'b0, 1'b0, acc);
            checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL freeze_valid: got %b expected 0", tx_valid); end
            checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL freeze_level: got %0d expected 1", fifo_level); end
        end
        checks++; if (obs.size() != 0) begin errors++; $display("FAIL freeze_words: got %0d expected 0", obs.size()); end
        repeat (3) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        classify();
        checks++;
        if (data_w.size() != 1) begin
            errors++; $display("FAIL resume_count: got %0d expected 1", data_w.size());
        end else begin
            checks++; if (data_w[0].lanes !== 32'h04030201) begin errors++; $display("FAIL resume_word: got %h expected 04030201", data_w[0].lanes); end
        end
    endtask

    task automatic test_random();
        bit acc;
        bit v, e, k;
        logic [7:0] d;
        int guard = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 9) != 0);
            k = ($urandom_range(0, 7) == 0);
            d = 8'($urandom);
            if (k && d == COM) d = 8'h3C;
            drive_cycle(v, d, k, e, acc);
            if (fifo_level == 4'd8) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rand_full_ready: got %b expected 0", in_ready); end
            end
        end
        while (model.size() % 4 != 0 && guard < 50) begin
            drive_cycle(1'b1, 8'h5A, 1'b0, 1'b1, acc);
            guard++;
        end
        repeat (60) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        classify();
        checks++; if (!pairs_ok) begin errors++; $display("FAIL rand_skp_pairs: got 0 expected 1"); end
        checks++; if (com_idx.size() < 2) begin errors++; $display("FAIL rand_skp_count: got %0d expected >=2", com_idx.size()); end
        checks++; if (data_w.size() != model.size() / 4) begin errors++; $display("FAIL rand_words: got %0d expected %0d", data_w.size(), model.size() / 4); end
        for (int w = 0; w < data_w.size() && w < model.size() / 4; w++) begin
            checks++;
            if (data_w[w].lanes !== exp_lanes(w) || data_w[w].k !== exp_k(w)) begin
                errors++; $display("FAIL rand_data[%0d]: got %h/%b expected %h/%b", w, data_w[w].lanes, data_w[w].k, exp_lanes(w), exp_k(w));
            end
        end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rand_drain: got %0d expected 0", fifo_level); end
    endtask

`ifdef TX_LANE_REVERSAL_EN
    task automatic test_lane_rev();
        bit acc;
        do_reset();
        lane_rev = 1'b1;
        for (int i = 1; i <= 4; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b1, acc);
        repeat (6) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        lane_rev = 1'b0;
        classify();
        checks++;
        if (data_w.size() != 1) begin
            errors++; $display("FAIL rev_count: got %0d expected 1", data_w.size());
        end else begin
            checks++; if (data_w[0].lanes !== 32'h01020304) begin errors++; $display("FAIL rev_word: got %h expected 01020304", data_w[0].lanes); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_k_stall();
        test_skp_full();
        test_enb_freeze();
        test_random();
`ifdef TX_LANE_REVERSAL_EN
        test_lane_rev();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
